// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I core sequencing controller: control bundle, FSM states, halt/trap causes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    // EBREAK is SYSTEM with imm=1 and zero rs1/funct3/rd, i.e. instr[31:7] == 25'h2000.
    localparam logic [24:0] EBREAK_HI  = 25'h0002000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
    } ctrl_signals_t;

    typedef enum logic [3:0] {
        CPU_RESET,
        CPU_FETCH,
        CPU_DECODE,
        CPU_EXECUTE,
        CPU_MEM_WAIT,
        CPU_WRITEBACK,
        CPU_TRAP,
        CPU_HALTED,
        CPU_STEP
    } cpu_state_e;

    typedef enum logic [2:0] {
        HALT_NONE,
        HALT_REQUEST,
        HALT_BREAKPOINT,
        HALT_EBREAK,
        HALT_STEP,
        HALT_TRAP
    } halt_cause_e;

    typedef enum logic [2:0] {
        TRAP_NONE,
        TRAP_ILLEGAL,
        TRAP_FETCH_ERR,
        TRAP_LSU_ERR,
        TRAP_TIMEOUT
    } trap_cause_e;

    function automatic logic is_ebreak(input logic [ILEN-1:0] instr);
        return (instr[6:0] == OPC_SYSTEM) && (instr[31:7] == EBREAK_HI);
    endfunction

endpackage

// File: rtl/rv32i_branch_eval.sv
// Branch-taken decision from funct3 and ALU flags.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_funct3 (branch type), i_alu_zero (result == 0), i_alu_lt (SLT/SLTU outcome), o_taken.
module rv32i_branch_eval
    import rv32i_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_alu_zero,
    input  logic       i_alu_lt,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_alu_zero;
            F3_BNE:  o_taken = !i_alu_zero;
            F3_BLT:  o_taken = i_alu_lt;
            F3_BGE:  o_taken = !i_alu_lt;
            F3_BLTU: o_taken = i_alu_lt;
            F3_BGEU: o_taken = !i_alu_lt;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle sequencer: fetch/decode/execute/mem/writeback with precise traps, debug halt/step, retire counter.
// Latency: ALU op 4 cycles FETCH->FETCH with zero-wait memory, load/store 5; outputs combinational from state+inputs.
// Backpressure: stalls in FETCH/MEM_WAIT until i_mem_valid; traps after MEM_TIMEOUT stalled cycles (0 = never).
// Ports: decoder/ALU inputs (i_instr, i_ctrl, i_illegal_instr, i_alu_*), memory handshake (i_mem_*, o_mem_*),
//        debug (i_dbg_*, i_bp_hit, o_halted, o_halt_cause), PC controls (o_pc_*), trap/retire status.
module rv32i_seq_ctrl
    import rv32i_pkg::*;
#(
    parameter int STEP_W       = 8,
    parameter int RET_W        = 32,
    parameter int MEM_TIMEOUT  = 256,
    parameter bit HALT_ON_TRAP = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ILEN-1:0]     i_instr,
    input  ctrl_signals_t       i_ctrl,
    input  logic                i_illegal_instr,
    input  logic                i_alu_zero,
    input  logic [XLEN-1:0]     i_alu_result,
    input  logic                i_mem_valid,
    input  logic                i_mem_err,
    input  logic                i_dbg_halt_req,
    input  logic                i_dbg_resume_req,
    input  logic                i_dbg_step_req,
    input  logic [STEP_W-1:0]   i_dbg_step_count,
    input  logic                i_bp_hit,
    output cpu_state_e          o_cpu_state,
    output logic                o_pc_we,
    output logic                o_pc_sel_branch,
    output logic                o_pc_sel_jump,
    output logic                o_pc_sel_trap,
    output logic                o_instr_valid,
    output logic                o_stall,
    output logic                o_halted,
    output halt_cause_e         o_halt_cause,
    output logic                o_trap_valid,
    output trap_cause_e         o_trap_cause,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic                o_retire,
    output logic [RET_W-1:0]    o_instret
);

    localparam int              TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    cpu_state_e         r_state;
    halt_cause_e        r_halt_cause;
    trap_cause_e        r_trap_cause;
    logic [RET_W-1:0]   r_instret;
    logic [STEP_W-1:0]  r_step_rem;
    logic [TO_W-1:0]    r_to_cnt;

    cpu_state_e         w_next;
    halt_cause_e        w_halt_cause;
    trap_cause_e        w_trap_cause;
    logic               w_br_taken;
    logic               w_to_hit;
    logic               w_step_last;
    logic               w_unused_alu;

    // Only the compare bit of the ALU result matters for branch resolution.
    assign w_unused_alu = ^i_alu_result[XLEN-1:1];

    rv32i_branch_eval u_branch_eval (
        .i_funct3   (i_instr[14:12]),
        .i_alu_zero (i_alu_zero),
        .i_alu_lt   (i_alu_result[0]),
        .o_taken    (w_br_taken)
    );

    assign w_to_hit    = TO_EN && (r_to_cnt == TO_LAST);
    assign w_step_last = (r_step_rem == STEP_W'(1));

    assign o_cpu_state  = r_state;
    assign o_halt_cause = r_halt_cause;
    assign o_trap_cause = r_trap_cause;
    assign o_instret    = r_instret;

    always_comb begin
        w_next          = r_state;
        w_halt_cause    = HALT_NONE;
        w_trap_cause    = TRAP_NONE;
        o_pc_we         = 1'b0;
        o_pc_sel_branch = 1'b0;
        o_pc_sel_jump   = 1'b0;
        o_pc_sel_trap   = 1'b0;
        o_instr_valid   = 1'b0;
        o_stall         = 1'b0;
        o_halted        = 1'b0;
        o_trap_valid    = 1'b0;
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_retire        = 1'b0;

        case (r_state)
            CPU_RESET: w_next = CPU_FETCH;

            CPU_FETCH: begin
                // Halt and breakpoint are resolved before any fetch is issued.
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else if (i_bp_hit) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_BREAKPOINT;
                end else begin
                    o_mem_req = 1'b1;
                    if (i_mem_valid && i_mem_err) begin
                        w_next       = CPU_TRAP;
                        w_trap_cause = TRAP_FETCH_ERR;
                    end else if (i_mem_valid) begin
                        w_next = CPU_DECODE;
                    end else begin
                        o_stall = 1'b1;
                        if (w_to_hit) begin
                            w_next       = CPU_TRAP;
                            w_trap_cause = TRAP_TIMEOUT;
                        end
                    end
                end
            end

            CPU_DECODE: begin
                o_instr_valid = 1'b1;
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else if (i_illegal_instr) begin
                    w_next       = CPU_TRAP;
                    w_trap_cause = TRAP_ILLEGAL;
                end else if (is_ebreak(i_instr)) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_EBREAK;
                end else begin
                    w_next = CPU_EXECUTE;
                end
            end

            CPU_EXECUTE: begin
                o_instr_valid = 1'b1;
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else if (i_ctrl.mem_read || i_ctrl.mem_write) begin
                    w_next = CPU_MEM_WAIT;
                end else begin
                    w_next = CPU_WRITEBACK;
                end
            end

            CPU_MEM_WAIT: begin
                o_instr_valid = 1'b1;
                // A halt drops the outstanding access; the request strobe goes low this cycle.
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else begin
                    o_mem_req = 1'b1;
                    o_mem_we  = i_ctrl.mem_write;
                    if (i_mem_valid && i_mem_err) begin
                        w_next       = CPU_TRAP;
                        w_trap_cause = TRAP_LSU_ERR;
                    end else if (i_mem_valid) begin
                        w_next = CPU_WRITEBACK;
                    end else begin
                        o_stall = 1'b1;
                        if (w_to_hit) begin
                            w_next       = CPU_TRAP;
                            w_trap_cause = TRAP_TIMEOUT;
                        end
                    end
                end
            end

            CPU_WRITEBACK: begin
                o_instr_valid = 1'b1;
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else begin
                    o_pc_we         = 1'b1;
                    o_pc_sel_jump   = i_ctrl.jump;
                    o_pc_sel_branch = i_ctrl.branch && !i_ctrl.jump && w_br_taken;
                    o_retire        = 1'b1;
                    if (w_step_last) begin
                        w_next       = CPU_HALTED;
                        w_halt_cause = HALT_STEP;
                    end else begin
                        w_next = CPU_FETCH;
                    end
                end
            end

            CPU_TRAP: begin
                // Single-cycle redirect; a halt request is only acted on as we leave.
                o_pc_we       = 1'b1;
                o_pc_sel_trap = 1'b1;
                o_trap_valid  = 1'b1;
                if (i_dbg_halt_req) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_REQUEST;
                end else if (w_step_last || HALT_ON_TRAP) begin
                    w_next       = CPU_HALTED;
                    w_halt_cause = HALT_TRAP;
                end else begin
                    w_next = CPU_FETCH;
                end
            end

            CPU_HALTED: begin
                o_halted = 1'b1;
                if (i_dbg_resume_req) begin
                    w_next = CPU_FETCH;
                end else if (i_dbg_step_req) begin
                    w_next = CPU_STEP;
                end
            end

            CPU_STEP: w_next = CPU_FETCH;

            default: w_next = CPU_RESET;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= CPU_RESET;
            r_halt_cause <= HALT_NONE;
            r_trap_cause <= TRAP_NONE;
            r_instret    <= '0;
            r_step_rem   <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_state <= w_next;

            // Counts only while parked in a stalled FETCH/MEM_WAIT; any state change
            // (including entry to either wait state, or completion) restarts it.
            if (o_stall && (w_next == r_state)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if ((w_next == CPU_HALTED) && (r_state != CPU_HALTED)) begin
                r_halt_cause <= w_halt_cause;
            end else if ((r_state == CPU_HALTED) && (w_next != CPU_HALTED)) begin
                r_halt_cause <= HALT_NONE;
            end

            if (w_next == CPU_TRAP) begin
                r_trap_cause <= w_trap_cause;
            end

            if (w_next == CPU_HALTED) begin
                r_step_rem <= '0;
            end else if (r_state == CPU_HALTED) begin
                if (i_dbg_resume_req) begin
                    r_step_rem <= '0;
                end else if (i_dbg_step_req) begin
                    r_step_rem <= (i_dbg_step_count == '0) ? STEP_W'(1) : i_dbg_step_count;
                end
            end else if ((o_retire || o_trap_valid) && (r_step_rem != '0)) begin
                r_step_rem <= r_step_rem - 1'b1;
            end

            if (o_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
module tb_rv32i_seq_ctrl;
    import rv32i_pkg::*;

    localparam int EV_RET  = 0;
    localparam int EV_TRAP = 1;
    localparam int EV_HALT = 2;
    localparam logic [31:0] I_ADD = 32'h002081B3;

    typedef struct {
        int          kind;
        logic        br;
        logic        jmp;
        trap_cause_e tc;
        halt_cause_e hc;
        logic [31:0] ir;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [31:0]   i_instr;
    ctrl_signals_t i_ctrl;
    logic          i_illegal_instr;
    logic          i_alu_zero;
    logic [31:0]   i_alu_result;
    logic          i_mem_valid;
    logic          i_mem_err;
    logic          i_dbg_halt_req;
    logic          i_dbg_resume_req;
    logic          i_dbg_step_req;
    logic [7:0]    i_dbg_step_count;
    logic          i_bp_hit;
    cpu_state_e    o_cpu_state;
    logic          o_pc_we, o_pc_sel_branch, o_pc_sel_jump, o_pc_sel_trap;
    logic          o_instr_valid, o_stall, o_halted, o_trap_valid;
    logic          o_mem_req, o_mem_we, o_retire;
    halt_cause_e   o_halt_cause;
    trap_cause_e   o_trap_cause;
    logic [31:0]   o_instret;

    rv32i_seq_ctrl #(
        .STEP_W(8), .RET_W(32), .MEM_TIMEOUT(8), .HALT_ON_TRAP(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_ctrl(i_ctrl),
        .i_illegal_instr(i_illegal_instr), .i_alu_zero(i_alu_zero), .i_alu_result(i_alu_result),
        .i_mem_valid(i_mem_valid), .i_mem_err(i_mem_err),
        .i_dbg_halt_req(i_dbg_halt_req), .i_dbg_resume_req(i_dbg_resume_req),
        .i_dbg_step_req(i_dbg_step_req), .i_dbg_step_count(i_dbg_step_count), .i_bp_hit(i_bp_hit),
        .o_cpu_state(o_cpu_state), .o_pc_we(o_pc_we), .o_pc_sel_branch(o_pc_sel_branch),
        .o_pc_sel_jump(o_pc_sel_jump), .o_pc_sel_trap(o_pc_sel_trap), .o_instr_valid(o_instr_valid),
        .o_stall(o_stall), .o_halted(o_halted), .o_halt_cause(o_halt_cause),
        .o_trap_valid(o_trap_valid), .o_trap_cause(o_trap_cause), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_retire(o_retire), .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    logic [10:0] w_bits;
    assign w_bits = {o_pc_we, o_pc_sel_branch, o_pc_sel_jump, o_pc_sel_trap, o_instr_valid,
                     o_stall, o_halted, o_trap_valid, o_mem_req, o_mem_we, o_retire};

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_ret = 0;
    logic        mem_auto = 1'b1;
    logic        prev_halted = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ret(input logic br, input logic jmp);
        exp_t e;
        e.kind = EV_RET; e.br = br; e.jmp = jmp; e.tc = TRAP_NONE; e.hc = HALT_NONE; e.ir = m_ret;
        sb.push_back(e);
        m_ret++;
    endfunction

    function automatic void push_trap(input trap_cause_e tc);
        exp_t e;
        e.kind = EV_TRAP; e.br = 1'b0; e.jmp = 1'b0; e.tc = tc; e.hc = HALT_NONE; e.ir = m_ret;
        sb.push_back(e);
    endfunction

    function automatic void push_halt(input halt_cause_e hc);
        exp_t e;
        e.kind = EV_HALT; e.br = 1'b0; e.jmp = 1'b0; e.tc = TRAP_NONE; e.hc = hc; e.ir = m_ret;
        sb.push_back(e);
    endfunction

    // Memory responder: zero-wait completion whenever the FSM is waiting on memory.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (mem_auto) i_mem_valid = (o_cpu_state == CPU_FETCH) || (o_cpu_state == CPU_MEM_WAIT);
    endtask

    task automatic wait_state(input cpu_state_e st, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((o_cpu_state != st) && (n < budget));
        if (o_cpu_state != st) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_%s: state %0d after %0d cycles", st.name(), o_cpu_state, n);
        end
    endtask

    task automatic resume();
        i_dbg_resume_req = 1'b1;
        tick();
        i_dbg_resume_req = 1'b0;
    endtask

    task automatic halt_here();
        push_halt(HALT_REQUEST);
        i_dbg_halt_req = 1'b1;
        tick();
        i_dbg_halt_req = 1'b0;
        check("halt_req_state", o_cpu_state, CPU_HALTED);
    endtask

    // Monitor: every retire, trap redirect and entry to HALTED must match the next expectation.
    always @(negedge i_clk) begin : mon
        int   k;
        exp_t e;
        if (!i_rst && (o_retire || o_trap_valid || (o_halted && !prev_halted))) begin
            k = o_retire ? EV_RET : (o_trap_valid ? EV_TRAP : EV_HALT);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
            end else begin
                e = sb.pop_front();
                check("event_kind", k, e.kind);
                if (k == e.kind) begin
                    case (k)
                        EV_RET: begin
                            check("ret_pc_we", o_pc_we, 1'b1);
                            check("ret_sel_branch", o_pc_sel_branch, e.br);
                            check("ret_sel_jump", o_pc_sel_jump, e.jmp);
                            check("ret_instret", o_instret, e.ir);
                        end
                        EV_TRAP: begin
                            check("trap_sel", {o_pc_we, o_pc_sel_trap, o_retire}, 3'b110);
                            check("trap_cause", o_trap_cause, e.tc);
                            check("trap_instret", o_instret, e.ir);
                        end
                        default: begin
                            check("halt_cause", o_halt_cause, e.hc);
                            check("halt_instret", o_instret, e.ir);
                        end
                    endcase
                end
            end
        end
        prev_halted = o_halted;
    end

    logic [2:0] bt_f3  [7] = '{3'b001, 3'b111, 3'b000, 3'b100, 3'b101, 3'b110, 3'b000};
    logic       bt_z   [7] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    logic       bt_r   [7] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
    logic       bt_exp [7] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};

    initial begin
        int n;
        i_rst = 1'b1; i_instr = I_ADD; i_ctrl = '0; i_illegal_instr = 1'b0;
        i_alu_zero = 1'b0; i_alu_result = '0; i_mem_valid = 1'b0; i_mem_err = 1'b0;
        i_dbg_halt_req = 1'b0; i_dbg_resume_req = 1'b0; i_dbg_step_req = 1'b0;
        i_dbg_step_count = '0; i_bp_hit = 1'b0;
        tick();
        tick();
        check("rst_state", o_cpu_state, CPU_RESET);
        check("rst_halt_cause", o_halt_cause, HALT_NONE);
        check("rst_trap_cause", o_trap_cause, TRAP_NONE);
        check("rst_instret", o_instret, 32'd0);
        check("rst_1bit_outs", w_bits, 11'd0);

        i_rst = 1'b0;
        tick();
        check("reset_to_fetch", o_cpu_state, CPU_FETCH);

        // ADD with zero-wait memory: 4 cycles FETCH->FETCH.
        push_ret(1'b0, 1'b0);
        wait_state(CPU_FETCH, 20, n);
        check("add_latency", n, 4);
        halt_here();
        check("add_instret", o_instret, 32'd1);

        // Store: 5 cycles, write strobe during MEM_WAIT.
        i_ctrl.mem_write = 1'b1;
        push_ret(1'b0, 1'b0);
        resume();
        check("resume_cause_none", o_halt_cause, HALT_NONE);
        wait_state(CPU_MEM_WAIT, 10, n);
        check("store_to_memwait", n, 3);
        check("store_strobes", {o_mem_req, o_mem_we}, 2'b11);
        wait_state(CPU_FETCH, 10, n);
        check("store_memwait_to_fetch", n, 2);
        halt_here();
        i_ctrl = '0;

        // Branch resolution table, then a jump.
        resume();
        for (int i = 0; i < 7; i++) begin
            i_instr = {17'h0, bt_f3[i], 5'h0, 7'b1100011};
            i_ctrl = '0;
            i_ctrl.branch = 1'b1;
            i_alu_zero = bt_z[i];
            i_alu_result = {31'h0, bt_r[i]};
            push_ret(bt_exp[i], 1'b0);
            wait_state(CPU_FETCH, 20, n);
        end
        i_instr = 32'h0080006F;
        i_ctrl = '0;
        i_ctrl.jump = 1'b1;
        push_ret(1'b0, 1'b1);
        wait_state(CPU_FETCH, 20, n);
        halt_here();
        i_ctrl = '0; i_instr = I_ADD; i_alu_zero = 1'b0; i_alu_result = '0;

        // Illegal instruction: one-cycle trap, then halt with HALT_TRAP, no retire.
        i_illegal_instr = 1'b1;
        push_trap(TRAP_ILLEGAL);
        push_halt(HALT_TRAP);
        resume();
        wait_state(CPU_HALTED, 10, n);
        check("illegal_to_halt", n, 3);
        check("illegal_trap_cause", o_trap_cause, TRAP_ILLEGAL);
        check("illegal_instret", o_instret, m_ret);
        i_illegal_instr = 1'b0;

        // Load whose memory never answers: trap on the 8th stalled MEM_WAIT cycle.
        i_ctrl.mem_read = 1'b1;
        push_trap(TRAP_TIMEOUT);
        push_halt(HALT_TRAP);
        resume();
        tick();
        mem_auto = 1'b0;
        i_mem_valid = 1'b0;
        wait_state(CPU_MEM_WAIT, 5, n);
        check("timeout_stall", o_stall, 1'b1);
        wait_state(CPU_TRAP, 20, n);
        check("timeout_cycles", n, 8);
        wait_state(CPU_HALTED, 3, n);
        mem_auto = 1'b1;
        i_ctrl = '0;

        // Step 3 instructions, then step with count 0 (one instruction).
        i_dbg_step_count = 8'd3;
        push_ret(1'b0, 1'b0); push_ret(1'b0, 1'b0); push_ret(1'b0, 1'b0);
        push_halt(HALT_STEP);
        i_dbg_step_req = 1'b1;
        tick();
        i_dbg_step_req = 1'b0;
        check("step_state", o_cpu_state, CPU_STEP);
        wait_state(CPU_HALTED, 40, n);
        check("step3_cycles", n, 13);
        check("step3_instret", o_instret, m_ret);
        i_dbg_step_count = 8'd0;
        push_ret(1'b0, 1'b0);
        push_halt(HALT_STEP);
        i_dbg_step_req = 1'b1;
        tick();
        i_dbg_step_req = 1'b0;
        wait_state(CPU_HALTED, 40, n);
        check("step0_cycles", n, 5);

        // Halt request coinciding with mem_valid in MEM_WAIT: halt wins, nothing retires.
        i_ctrl.mem_read = 1'b1;
        resume();
        wait_state(CPU_MEM_WAIT, 5, n);
        halt_here();
        check("halt_vs_valid_instret", o_instret, m_ret);
        i_ctrl = '0;

        // Breakpoint at FETCH: no memory request issued.
        i_bp_hit = 1'b1;
        push_halt(HALT_BREAKPOINT);
        resume();
        check("bp_no_mem_req", o_mem_req, 1'b0);
        tick();
        i_bp_hit = 1'b0;
        check("bp_state", o_cpu_state, CPU_HALTED);

        // EBREAK in DECODE.
        i_instr = 32'h00100073;
        push_halt(HALT_EBREAK);
        resume();
        wait_state(CPU_HALTED, 5, n);
        check("ebreak_cycles", n, 2);
        i_instr = I_ADD;

        // Fetch bus error.
        mem_auto = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_err = 1'b1;
        push_trap(TRAP_FETCH_ERR);
        push_halt(HALT_TRAP);
        resume();
        wait_state(CPU_HALTED, 5, n);
        check("fetch_err_cycles", n, 2);
        i_mem_err = 1'b0;
        i_mem_valid = 1'b0;
        mem_auto = 1'b1;

        // Load/store bus error.
        i_ctrl.mem_read = 1'b1;
        push_trap(TRAP_LSU_ERR);
        push_halt(HALT_TRAP);
        resume();
        wait_state(CPU_MEM_WAIT, 5, n);
        i_mem_err = 1'b1;
        wait_state(CPU_HALTED, 5, n);
        i_mem_err = 1'b0;

        // Reset pulsed during a stalled MEM_WAIT.
        resume();
        tick();
        mem_auto = 1'b0;
        i_mem_valid = 1'b0;
        wait_state(CPU_MEM_WAIT, 5, n);
        tick();
        i_rst = 1'b1;
        tick();
        check("midrst_state", o_cpu_state, CPU_RESET);
        check("midrst_1bit_outs", w_bits, 11'd0);
        check("midrst_instret", o_instret, 32'd0);
        check("midrst_halt_cause", o_halt_cause, HALT_NONE);
        check("midrst_trap_cause", o_trap_cause, TRAP_NONE);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
